// File: rtl/snake_dir_ctrl_pkg.sv
// Shared constants for the snake direction controller: direction codes, game-state codes, queue depth.
// Latency: n/a (definitions only).
// Backpressure: n/a. Queue depth is set by SNAKE_DIR_QUEUE_EN (defined: 2 entries, undefined: 1 entry).

`ifndef DIR_OPPOSITE
  // Codes are chosen so that flipping bit 1 gives the opposite heading.
  `define DIR_OPPOSITE(d) ((d) ^ 2'b10)
`endif

package snake_dir_ctrl_pkg;

  localparam int DIR_W   = 2;
  localparam int STATE_W = 3;

  // LEFT<->RIGHT and TOP<->DOWN differ only in bit 1.
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd0;
  localparam logic [DIR_W-1:0] DIR_TOP   = 2'd1;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd2;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd3;

  localparam logic [STATE_W-1:0] STATE_MENU   = 3'd0;
  localparam logic [STATE_W-1:0] STATE_INGAME = 3'd1;
  localparam logic [STATE_W-1:0] STATE_PAUSE  = 3'd2;
  localparam logic [STATE_W-1:0] STATE_OVER   = 3'd3;

`ifdef SNAKE_DIR_QUEUE_EN
  localparam int Q_DEPTH = 2;
`else
  localparam int Q_DEPTH = 1;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] d);
    return `DIR_OPPOSITE(d);
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Bundle of button inputs, step strobe, game state and the resulting direction outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, the consumer samples direction every step.

interface snake_dir_ctrl_if;
  import snake_dir_ctrl_pkg::*;

  logic [3:0]         btn_raw;      // {up,right,down,left}
  logic               update_tick;
  logic [STATE_W-1:0] game_state;
  logic [DIR_W-1:0]   direction;
  logic               dir_changed;
  logic [1:0]         pending_cnt;

  modport master (
    output btn_raw, update_tick, game_state,
    input  direction, dir_changed, pending_cnt
  );

  modport slave (
    input  btn_raw, update_tick, game_state,
    output direction, dir_changed, pending_cnt
  );
endinterface

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, rising-edge pulse of the debounced level.
// Latency: raw edge to press pulse is 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; a press is a single-cycle pulse that is either consumed or lost.

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic vga_clk,
  input  logic reset_p,
  input  logic raw,
  output logic press
);

  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the vga_clk domain.
  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) sync <= 2'b00;
    else         sync <= {sync[0], raw};
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES samples.
  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Remember the previous debounced level for edge detection.
  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) level_d <= 1'b0;
    else         level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns four debounced buttons into the snake heading, queueing turns and applying one per update_tick.
// Latency: press to queue 1 cycle; tick to direction/dir_changed 1 cycle. SNAKE_DIR_QUEUE_EN selects a 2-deep queue.
// Backpressure: none upstream; a press arriving while the queue is full (and nothing pops) is dropped.

module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter int               CNT_W           = 18,
  parameter logic [DIR_W-1:0] INIT_DIR        = DIR_RIGHT
) (
  input logic             vga_clk,
  input logic             reset_p,
  snake_dir_ctrl_if.slave bus
);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .vga_clk(vga_clk),
      .reset_p(reset_p),
      .raw    (bus.btn_raw[i]),
      .press  (press[i])
    );
  end

  state_t                         state, state_nxt;
  logic [Q_DEPTH-1:0][DIR_W-1:0]  q, q_nxt;
  logic [1:0]                     cnt, cnt_nxt;
  logic [DIR_W-1:0]               dir_q, dir_nxt;
  logic                           chg_q, chg_nxt;
  logic                           run;
  logic                           accept;
  logic [DIR_W-1:0]               cand;
  logic [DIR_W-1:0]               ref_dir;

  // State, queue and heading registers.
  always_ff @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      state <= ST_IDLE;
      q     <= '0;
      cnt   <= 2'd0;
      dir_q <= INIT_DIR;
      chg_q <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
      chg_q <= chg_nxt;
    end
  end

  // Next state, arbitration, pop-then-push queue update and apply.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    chg_nxt   = 1'b0;
    run       = 1'b0;
    accept    = 1'b0;
    ref_dir   = dir_q;

    // Up wins over right over down over left; the rest are dropped.
    cand = DIR_LEFT;
    if      (press[3]) cand = DIR_TOP;
    else if (press[2]) cand = DIR_RIGHT;
    else if (press[1]) cand = DIR_DOWN;

    // Entry into the game takes effect in the same cycle, as does leaving it.
    case (state)
      ST_IDLE: if (bus.game_state == STATE_INGAME) begin
        state_nxt = ST_RUN;
        run       = 1'b1;
      end
      ST_RUN: if (bus.game_state != STATE_INGAME) state_nxt = ST_IDLE;
              else run = 1'b1;
    endcase

    if (!run) begin
      cnt_nxt = 2'd0;
      dir_nxt = INIT_DIR;
    end else begin
      // Pop first so a same-cycle push sees the post-pop queue and new heading.
      if (bus.update_tick && cnt != 2'd0) begin
        dir_nxt = q[0];
        chg_nxt = 1'b1;
`ifdef SNAKE_DIR_QUEUE_EN
        q_nxt[0] = q[1];
        cnt_nxt  = cnt - 2'd1;
`else
        cnt_nxt  = 2'd0;
`endif
      end

`ifdef SNAKE_DIR_QUEUE_EN
      if      (cnt_nxt == 2'd2) ref_dir = q_nxt[1];
      else if (cnt_nxt == 2'd1) ref_dir = q_nxt[0];
      else                      ref_dir = dir_nxt;
`else
      ref_dir = dir_nxt;
`endif

      accept = (|press) && (cand != ref_dir) && (cand != dir_opposite(ref_dir));

`ifdef SNAKE_DIR_QUEUE_EN
      if (accept && cnt_nxt != 2'd2) begin
        q_nxt[cnt_nxt[0]] = cand;
        cnt_nxt           = cnt_nxt + 2'd1;
      end
`else
      // Single slot: the latest accepted turn replaces any pending one.
      if (accept) begin
        q_nxt[0] = cand;
        cnt_nxt  = 2'd1;
      end
`endif
    end
  end

  assign bus.direction   = dir_q;
  assign bus.dir_changed = chg_q;
  assign bus.pending_cnt = cnt;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.

module tb_snake_dir_ctrl;
  import snake_dir_ctrl_pkg::*;

  localparam int D = 4;
`ifdef SNAKE_DIR_QUEUE_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif

  logic vga_clk = 1'b0;
  logic reset_p;

  snake_dir_ctrl_if ctrl();

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .vga_clk(vga_clk),
    .reset_p(reset_p),
    .bus    (ctrl)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Directions: 0=LEFT 1=TOP 2=RIGHT 3=DOWN; opposite = code ^ 2.
  int       m_q[$];
  int       m_dir = 2;
  bit       m_chg = 1'b0;
  bit [3:0] m_press = '0;
  bit [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int       m_streak[4] = '{0, 0, 0, 0};
  int       cand, refd;
  bit       was;

  always @(posedge vga_clk or posedge reset_p) begin
    if (reset_p) begin
      m_q.delete();
      m_dir   = 2;
      m_chg   = 1'b0;
      m_press = '0;
      m_s1    = '0;
      m_s2    = '0;
      m_lvl   = '0;
      for (int i = 0; i < 4; i++) m_streak[i] = 0;
    end else begin
      // Turn handling uses the presses detected at the previous edge.
      m_chg = 1'b0;
      if (ctrl.game_state != STATE_INGAME) begin
        m_q.delete();
        m_dir = 2;
      end else begin
        if (ctrl.update_tick && m_q.size() > 0) begin
          m_dir = m_q.pop_front();
          m_chg = 1'b1;
        end
        if (m_press != 4'b0000) begin
          cand = m_press[3] ? 1 : m_press[2] ? 2 : m_press[1] ? 3 : 0;
          refd = (QD == 2 && m_q.size() > 0) ? m_q[$] : m_dir;
          if (cand != refd && cand != (refd ^ 2)) begin
            if (QD == 1) begin
              m_q.delete();
              m_q.push_back(cand);
            end else if (m_q.size() < QD) begin
              m_q.push_back(cand);
            end
          end
        end
      end
      // A button level is accepted after D consecutive differing synchronised samples.
      for (int i = 0; i < 4; i++) begin
        was = m_lvl[i];
        if (m_s2[i] != m_lvl[i]) begin
          m_streak[i]++;
          if (m_streak[i] == D) begin
            m_lvl[i]    = ~m_lvl[i];
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
        m_press[i] = m_lvl[i] && !was;
        m_s2[i]    = m_s1[i];
        m_s1[i]    = ctrl.btn_raw[i];
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge vga_clk) begin
    check("direction", int'(ctrl.direction), m_dir);
    check("dir_changed", int'(ctrl.dir_changed), int'(m_chg));
    check("pending_cnt", int'(ctrl.pending_cnt), m_q.size());
    if (ctrl.dir_changed) chg_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic nxt(input int n);
    repeat (n) @(negedge vga_clk);
    #1;
  endtask

  task automatic tick();
    ctrl.update_tick = 1'b1;
    nxt(1);
    ctrl.update_tick = 1'b0;
    nxt(1);
  endtask

  task automatic press(input logic [3:0] m);
    ctrl.btn_raw = m;
    nxt(6);
    ctrl.btn_raw = 4'b0000;
    nxt(8);
  endtask

  task automatic leave_and_return();
    ctrl.game_state = STATE_MENU;
    nxt(1);
    ctrl.game_state = STATE_INGAME;
    nxt(1);
  endtask

  initial begin
    reset_p          = 1'b0;
    ctrl.btn_raw     = 4'b0000;
    ctrl.update_tick = 1'b0;
    ctrl.game_state  = STATE_INGAME;
    #1 reset_p = 1'b1;
    nxt(3);
    check("reset_direction", int'(ctrl.direction), 2);
    check("reset_pending", int'(ctrl.pending_cnt), 0);
    check("reset_dir_changed", int'(ctrl.dir_changed), 0);
    reset_p = 1'b0;
    nxt(1);

    // 1: idle ticks keep RIGHT, never pulse
    repeat (10) tick();
    check("t1_direction", int'(ctrl.direction), 2);
    check("t1_no_pulses", chg_seen, 0);

    // 2: 3-cycle glitch ignored; 10-cycle hold queues TOP
    ctrl.btn_raw = 4'b1000;
    nxt(3);
    ctrl.btn_raw = 4'b0000;
    nxt(10);
    check("t2_glitch_pending", int'(ctrl.pending_cnt), 0);
    ctrl.btn_raw = 4'b1000;
    nxt(10);
    ctrl.btn_raw = 4'b0000;
    nxt(8);
    check("t2_hold_pending", int'(ctrl.pending_cnt), 1);
    ctrl.update_tick = 1'b1;
    nxt(1);
    ctrl.update_tick = 1'b0;
    check("t2_tick_direction", int'(ctrl.direction), 1);
    check("t2_tick_pulse", int'(ctrl.dir_changed), 1);
    nxt(1);
    check("t2_pulse_one_cycle", int'(ctrl.dir_changed), 0);

    // 3: reversal dropped; two queued turns applied in order
    leave_and_return();
    check("t3_back_to_right", int'(ctrl.direction), 2);
    press(4'b0001);
    check("t3_reverse_dropped", int'(ctrl.pending_cnt), 0);
    press(4'b1000);
    press(4'b0001);
    check("t3_two_pending", int'(ctrl.pending_cnt), QD);
    tick();
    check("t3_first_tick", int'(ctrl.direction), 1);
    tick();
    check("t3_second_tick", int'(ctrl.direction), (QD == 2) ? 0 : 1);

    // 4: full queue drops; press coinciding with tick pops and pushes
    leave_and_return();
    press(4'b1000);
    press(4'b0001);
    press(4'b0010);
    check("t4_full_drop", int'(ctrl.pending_cnt), QD);
    ctrl.btn_raw = 4'b0010;
    nxt(6);
    ctrl.update_tick = 1'b1;
    nxt(1);
    ctrl.update_tick = 1'b0;
    check("t4_coincide_dir", int'(ctrl.direction), (QD == 2) ? 1 : 3);
    check("t4_coincide_pending", int'(ctrl.pending_cnt), (QD == 2) ? 2 : 0);
    ctrl.btn_raw = 4'b0000;
    nxt(8);

    // 5: simultaneous up+left -> up only; up then down
    leave_and_return();
    press(4'b1001);
    check("t5_simul_pending", int'(ctrl.pending_cnt), 1);
    tick();
    check("t5_simul_dir", int'(ctrl.direction), 1);
    leave_and_return();
    press(4'b1000);
    press(4'b0010);
    check("t5_updown_pending", int'(ctrl.pending_cnt), 1);
    tick();
    check("t5_updown_dir", int'(ctrl.direction), (QD == 2) ? 1 : 3);

    // 6: leaving the game clears queue; async reset mid-run
    leave_and_return();
    press(4'b1000);
    press(4'b0001);
    check("t6_pending_before_leave", int'(ctrl.pending_cnt), QD);
    ctrl.game_state = STATE_OVER;
    nxt(1);
    check("t6_leave_pending", int'(ctrl.pending_cnt), 0);
    check("t6_leave_direction", int'(ctrl.direction), 2);
    ctrl.game_state = STATE_INGAME;
    nxt(1);
    press(4'b1000);
    press(4'b0001);
    tick();
    press(4'b0010);
    check("t6_prereset_dir", int'(ctrl.direction), 1);
    check("t6_prereset_pending", int'(ctrl.pending_cnt), (QD == 2) ? 2 : 0);
    @(posedge vga_clk);
    #2 reset_p = 1'b1;
    #1;
    check("t6_async_direction", int'(ctrl.direction), 2);
    check("t6_async_pending", int'(ctrl.pending_cnt), 0);
    check("t6_async_dir_changed", int'(ctrl.dir_changed), 0);
    nxt(2);
    reset_p = 1'b0;
    nxt(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
